// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column scan, 2-FF row synchroniser, per-frame
// key classification, frame-level debounce and a press/release accept FSM.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DWELL    = 4,
    parameter int DEBOUNCE = 2,
    localparam int CW      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic [ROWS-1:0] read_row,
    output logic [COLS-1:0] scan_col,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_release,
    output logic            key_held,
    output logic            multi_key
);

    localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam logic [COLS-1:0] COL_FIRST = COLS'(1) << (COLS - 1);

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } result_e;

    typedef enum logic {
        IDLE,
        HELD
    } state_e;

    logic [ROWS-1:0] rowSync1_q, rowSync2_q;
    logic [COLS-1:0] scanCol_q;
    logic [DW-1:0]   dwellCnt_q;
    logic [COLW-1:0] colIdx_q;

    logic            accHit_q, accMulti_q;
    logic [CW-1:0]   accCode_q;

    result_e         prevKind_q, prevKind_d;
    logic [CW-1:0]   prevCode_q, prevCode_d;
    logic [DBW-1:0]  debCnt_q, debCnt_d;

    state_e          state_q, state_d;
    logic [CW-1:0]   keyCode_q, keyCode_d;
    logic            keyHeld_q, keyHeld_d;
    logic            multiKey_q, multiKey_d;
    logic            keyValid_q, keyValid_d;
    logic            keyRelease_q, keyRelease_d;

    logic            sampling, frameEnd;
    int              hits, rowNum, colNum;
    logic [CW-1:0]   sampCode;
    logic            frameHit, frameMulti;
    logic [CW-1:0]   frameCode;
    result_e         resKind;
    logic [CW-1:0]   resCode;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rowSync1_q <= '0;
            rowSync2_q <= '0;
        end else begin
            rowSync1_q <= read_row;
            rowSync2_q <= rowSync1_q;
        end
    end

    // A zero scan register marks the first cycle out of reset; colIdx_q counts
    // columns from the leftmost (index 0) towards column 0 (index COLS-1).
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            scanCol_q  <= '0;
            dwellCnt_q <= '0;
            colIdx_q   <= '0;
        end else if (scanCol_q == '0) begin
            scanCol_q <= COL_FIRST;
        end else if (dwellCnt_q == DW'(DWELL - 1)) begin
            dwellCnt_q <= '0;
            if (colIdx_q == COLW'(COLS - 1)) begin
                colIdx_q  <= '0;
                scanCol_q <= COL_FIRST;
            end else begin
                colIdx_q  <= colIdx_q + COLW'(1);
                scanCol_q <= scanCol_q >> 1;
            end
        end else begin
            dwellCnt_q <= dwellCnt_q + DW'(1);
        end
    end

    assign sampling = (scanCol_q != '0) && (dwellCnt_q == DW'(DWELL - 1));
    assign frameEnd = sampling && (colIdx_q == COLW'(COLS - 1));

    always_comb begin
        hits   = $countones(rowSync2_q);
        rowNum = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (rowSync2_q[r]) begin
                rowNum = r;
            end
        end
        colNum   = COLS - 1 - int'(colIdx_q);
        sampCode = CW'(rowNum * COLS + colNum);
    end

    // Fold the current sample into the running frame so the frame-end sample
    // is classified together with the earlier columns in the same cycle.
    always_comb begin
        frameHit   = accHit_q;
        frameMulti = accMulti_q;
        frameCode  = accCode_q;
        if (sampling) begin
            if (hits > 1) begin
                frameMulti = 1'b1;
            end else if (hits == 1) begin
                if (accHit_q) begin
                    frameMulti = 1'b1;
                end else begin
                    frameHit  = 1'b1;
                    frameCode = sampCode;
                end
            end
        end
        resKind = RES_NONE;
        resCode = '0;
        if (frameMulti) begin
            resKind = RES_MULTI;
        end else if (frameHit) begin
            resKind = RES_SINGLE;
            resCode = frameCode;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            accHit_q   <= 1'b0;
            accMulti_q <= 1'b0;
            accCode_q  <= '0;
        end else if (frameEnd) begin
            accHit_q   <= 1'b0;
            accMulti_q <= 1'b0;
            accCode_q  <= '0;
        end else if (sampling) begin
            accHit_q   <= frameHit;
            accMulti_q <= frameMulti;
            accCode_q  <= frameCode;
        end
    end

    // Debounce counts identical frame results; the accept decision uses the
    // updated count so a change is taken on its DEBOUNCE-th matching frame.
    always_comb begin
        prevKind_d   = prevKind_q;
        prevCode_d   = prevCode_q;
        debCnt_d     = debCnt_q;
        state_d      = state_q;
        keyCode_d    = keyCode_q;
        keyHeld_d    = keyHeld_q;
        multiKey_d   = multiKey_q;
        keyValid_d   = 1'b0;
        keyRelease_d = 1'b0;
        if (frameEnd) begin
            if ((resKind == prevKind_q) && (resCode == prevCode_q)) begin
                if (debCnt_q != DBW'(DEBOUNCE)) begin
                    debCnt_d = debCnt_q + DBW'(1);
                end
            end else begin
                debCnt_d   = DBW'(1);
                prevKind_d = resKind;
                prevCode_d = resCode;
            end
            if (debCnt_d == DBW'(DEBOUNCE)) begin
                case (resKind)
                    RES_MULTI: begin
                        multiKey_d = 1'b1;
                    end
                    RES_SINGLE: begin
                        multiKey_d = 1'b0;
                        if ((state_q == IDLE) || (resCode != keyCode_q)) begin
                            keyCode_d  = resCode;
                            keyHeld_d  = 1'b1;
                            keyValid_d = 1'b1;
                            state_d    = HELD;
                        end
                    end
                    default: begin
                        multiKey_d = 1'b0;
                        if (state_q == HELD) begin
                            keyHeld_d    = 1'b0;
                            keyRelease_d = 1'b1;
                            state_d      = IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            prevKind_q   <= RES_NONE;
            prevCode_q   <= '0;
            debCnt_q     <= '0;
            state_q      <= IDLE;
            keyCode_q    <= '0;
            keyHeld_q    <= 1'b0;
            multiKey_q   <= 1'b0;
            keyValid_q   <= 1'b0;
            keyRelease_q <= 1'b0;
        end else begin
            prevKind_q   <= prevKind_d;
            prevCode_q   <= prevCode_d;
            debCnt_q     <= debCnt_d;
            state_q      <= state_d;
            keyCode_q    <= keyCode_d;
            keyHeld_q    <= keyHeld_d;
            multiKey_q   <= multiKey_d;
            keyValid_q   <= keyValid_d;
            keyRelease_q <= keyRelease_d;
        end
    end

    assign scan_col    = scanCol_q;
    assign key_code    = keyCode_q;
    assign key_valid   = keyValid_q;
    assign key_release = keyRelease_q;
    assign key_held    = keyHeld_q;
    assign multi_key   = multiKey_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix driven from scan_col, with
// frame-aligned key changes checked against a frame-history reference model.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int DWELL    = 4;
    localparam int DEBOUNCE = 2;
    localparam int NKEYS    = ROWS * COLS;
    localparam int FRAME    = COLS * DWELL;
    localparam int CW       = $clog2(NKEYS);

    logic                clk;
    logic                nRst;
    logic [ROWS-1:0]     read_row;
    logic [COLS-1:0]     scan_col;
    logic [CW-1:0]       key_code;
    logic                key_valid;
    logic                key_release;
    logic                key_held;
    logic                multi_key;

    logic [NKEYS-1:0]    pressed;

    int                  testsRun;
    int                  testsFailed;

    int                  hist[$];
    logic                mHeld;
    logic                mMulti;
    int                  mCode;
    logic                expValid;
    logic                expRelease;

    keypad_scanner #(
        .ROWS(ROWS),
        .COLS(COLS),
        .DWELL(DWELL),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .read_row(read_row),
        .scan_col(scan_col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_release(key_release),
        .key_held(key_held),
        .multi_key(multi_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A pressed key connects its column drive to its row sense line.
    always_comb begin
        read_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (pressed[r * COLS + c] && scan_col[c]) begin
                    read_row[r] = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        mHeld      = 1'b0;
        mMulti     = 1'b0;
        mCode      = 0;
        expValid   = 1'b0;
        expRelease = 1'b0;
    endtask

    // Frame result: -1 none, -2 several keys, otherwise the single key index.
    task automatic modelFrame(input logic [NKEYS-1:0] keys);
        int  res;
        int  n;
        logic stable;
        n   = $countones(keys);
        res = -1;
        if (n > 1) begin
            res = -2;
        end else if (n == 1) begin
            for (int k = 0; k < NKEYS; k++) begin
                if (keys[k]) res = k;
            end
        end
        hist.push_back(res);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        expValid   = 1'b0;
        expRelease = 1'b0;
        stable     = (hist.size() == DEBOUNCE);
        foreach (hist[i]) begin
            if (hist[i] != res) stable = 1'b0;
        end
        if (stable) begin
            if (res == -2) begin
                mMulti = 1'b1;
            end else if (res == -1) begin
                mMulti = 1'b0;
                if (mHeld) begin
                    mHeld      = 1'b0;
                    expRelease = 1'b1;
                end
            end else begin
                mMulti = 1'b0;
                if (!mHeld || res != mCode) begin
                    mHeld    = 1'b1;
                    mCode    = res;
                    expValid = 1'b1;
                end
            end
        end
    endtask

    // Called on the negedge of a frame's first cycle; returns on the next one.
    task automatic applyStimulus(input logic [NKEYS-1:0] keys);
        int stray;
        int scanErr;
        logic [COLS-1:0] expScan;
        pressed = keys;
        stray   = 0;
        scanErr = 0;
        for (int k = 0; k < FRAME; k++) begin
            expScan = '0;
            expScan[COLS - 1 - k / DWELL] = 1'b1;
            if (scan_col !== expScan) scanErr++;
            if (k > 0 && (key_valid || key_release)) stray++;
            @(negedge clk);
        end
        modelFrame(keys);
        checkOutput("scan_sequence", scanErr, 0);
        checkOutput("stray_strobe", stray, 0);
        checkOutput("key_valid", {31'd0, key_valid}, {31'd0, expValid});
        checkOutput("key_release", {31'd0, key_release}, {31'd0, expRelease});
        checkOutput("key_held", {31'd0, key_held}, {31'd0, mHeld});
        checkOutput("multi_key", {31'd0, multi_key}, {31'd0, mMulti});
        checkOutput("key_code", {{(32-CW){1'b0}}, key_code}, mCode);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_scan"}, {28'd0, scan_col}, 0);
        checkOutput({tag, "_code"}, {{(32-CW){1'b0}}, key_code}, 0);
        checkOutput({tag, "_flags"}, {28'd0, key_valid, key_release, key_held, multi_key}, 0);
    endtask

    task automatic resetMidFrame();
        repeat (5) @(negedge clk);
        nRst = 1'b0;
        #1;
        checkAllZero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        modelReset();
        @(negedge clk);
    endtask

    task automatic holdFrames(input logic [NKEYS-1:0] keys, input int n);
        for (int i = 0; i < n; i++) applyStimulus(keys);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NKEYS-1:0] keys;
        int sel;
        testsRun    = 0;
        testsFailed = 0;
        pressed     = '0;
        nRst        = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        nRst = 1'b1;
        @(negedge clk);

        holdFrames('0, 3);

        holdFrames(NKEYS'(1) << 9, 3);
        holdFrames('0, 3);

        for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? (NKEYS'(1) << 5) : '0);
        holdFrames(NKEYS'(1) << 5, 3);
        holdFrames('0, 3);

        holdFrames((NKEYS'(1) << 0) | (NKEYS'(1) << 15), 3);
        holdFrames(NKEYS'(1) << 0, 3);
        holdFrames('0, 3);

        holdFrames(NKEYS'(1) << 5, 3);
        holdFrames(NKEYS'(1) << 6, 3);
        holdFrames('0, 3);

        holdFrames(NKEYS'(1) << 3, 3);
        resetMidFrame();
        holdFrames(NKEYS'(1) << 3, 3);
        holdFrames('0, 3);

        keys = '0;
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            if (sel >= 4 && sel <= 5) begin
                keys = '0;
            end else if (sel >= 6 && sel <= 8) begin
                keys = NKEYS'(1) << $urandom_range(0, NKEYS - 1);
            end else if (sel == 9) begin
                keys = (NKEYS'(1) << $urandom_range(0, NKEYS - 1))
                     | (NKEYS'(1) << $urandom_range(0, NKEYS - 1));
            end
            applyStimulus(keys);
        end
        holdFrames('0, 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
